// File: rtl/store_queue_commit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue_commit_pkg
//  Description : Store-queue sizing defaults and LSU-facing record types
//                (queue entry, forwarding request/response) shared by the
//                store queue and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_queue_commit_pkg;

    // Core-level store queue sizing; feeds the queue's DEPTH default.
    localparam int STQ_DEPTH    = 8;
    localparam int STQ_IDX      = $clog2(STQ_DEPTH);
    localparam int STQ_ROB_ID_W = 5;
    localparam int STQ_ADDR_W   = 32;
    localparam int STQ_DATA_W   = 32;
    localparam int STQ_MASK_W   = STQ_DATA_W / 8;

    // One store-queue slot as seen by the rest of the LSU.
    typedef struct packed {
        logic [STQ_ROB_ID_W-1:0] rob_id;
        logic                    addr_valid;
        logic [STQ_ADDR_W-1:0]   addr;
        logic [STQ_MASK_W-1:0]   mask;
        logic [STQ_DATA_W-1:0]   wdata;
    } stq_entry_t;

    // Load-side lookup into the store queue.
    typedef struct packed {
        logic                  valid;
        logic [STQ_ADDR_W-1:0] addr;
        logic [STQ_MASK_W-1:0] mask;
        logic [STQ_IDX:0]      age;
    } fwd_req_t;

    // Store-queue answer to a load lookup.
    typedef struct packed {
        logic [STQ_MASK_W-1:0] mask;
        logic [STQ_DATA_W-1:0] data;
        logic                  stall;
    } fwd_rsp_t;

endpackage
`default_nettype wire

// File: rtl/stq_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : stq_fwd_select
//  Description : Stateless per-byte store-to-load forwarding pick. Walks the
//                entries from oldest (rd_ptr) towards ld_age so that a
//                younger matching store overrides an older one byte by byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module stq_fwd_select
    import store_queue_commit_pkg::*;
#(
    parameter int DEPTH   = STQ_DEPTH,
    parameter int WADDR_W = 30,
    parameter int DATA_W  = 32,
    localparam int IDX    = $clog2(DEPTH),
    localparam int MASK_W = DATA_W / 8
) (
    input  logic                              ld_valid,
    input  logic [WADDR_W-1:0]                ld_waddr,
    input  logic [MASK_W-1:0]                 ld_mask,
    input  logic [IDX:0]                      ld_age,
    input  logic [IDX:0]                      rd_ptr,
    input  logic [DEPTH-1:0]                  addr_valid,
    input  logic [DEPTH-1:0][WADDR_W-1:0]     waddr,
    input  logic [DEPTH-1:0][MASK_W-1:0]      mask,
    input  logic [DEPTH-1:0][DATA_W-1:0]      wdata,
    output logic [MASK_W-1:0]                 fwd_mask,
    output logic [DATA_W-1:0]                 fwd_data,
    output logic                              fwd_stall
);

    logic [IDX:0]   w_span;
    logic [IDX-1:0] w_idx;

    // Age-ordered scan: span is measured from rd_ptr with the wrap flag, so
    // physical index order never decides age.
    always_comb begin
        fwd_mask  = '0;
        fwd_data  = '0;
        fwd_stall = 1'b0;
        w_span    = ld_age - rd_ptr;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = rd_ptr[IDX-1:0] + k[IDX-1:0];
            if (ld_valid && ((IDX+1)'(k) < w_span)) begin
                if (!addr_valid[w_idx]) begin
                    fwd_stall = 1'b1;
                end else if (waddr[w_idx] == ld_waddr) begin
                    for (int b = 0; b < MASK_W; b++) begin
                        if (ld_mask[b] && mask[w_idx][b]) begin
                            fwd_mask[b]         = 1'b1;
                            fwd_data[8*b +: 8]  = wdata[w_idx][8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_queue_commit.sv
`default_nettype none
// ============================================================================
//  Module      : store_queue_commit
//  Description : Circular store queue with three age regions: committed
//                [rd_ptr, cmt_ptr) draining to the DCache, speculative
//                [cmt_ptr, wr_ptr) awaiting retirement, and free. Flush drops
//                only the speculative region. Byte-wise forwarding to loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_queue_commit
    import store_queue_commit_pkg::*;
#(
    parameter int DEPTH    = STQ_DEPTH,
    parameter int ROB_ID_W = STQ_ROB_ID_W,
    parameter int ADDR_W   = STQ_ADDR_W,
    parameter int DATA_W   = STQ_DATA_W,
    localparam int IDX     = $clog2(DEPTH),
    localparam int MASK_W  = DATA_W / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                enq_valid,
    input  logic [ROB_ID_W-1:0] enq_rob_id,
    output logic                enq_ready,
    output logic [IDX:0]        enq_ptr,
    input  logic                agu_valid,
    input  logic [IDX:0]        agu_ptr,
    input  logic [ADDR_W-1:0]   agu_addr,
    input  logic [MASK_W-1:0]   agu_mask,
    input  logic [DATA_W-1:0]   agu_wdata,
    output logic                cmt_ready,
    output logic [ROB_ID_W-1:0] cmt_rob_id,
    input  logic                cmt_valid,
    output logic                dmem_valid,
    input  logic                dmem_ready,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [MASK_W-1:0]   dmem_wmask,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [MASK_W-1:0]   ld_mask,
    input  logic [IDX:0]        ld_age,
    output logic [MASK_W-1:0]   fwd_mask,
    output logic [DATA_W-1:0]   fwd_data,
    output logic                fwd_stall,
    output logic [IDX:0]        count
);

    localparam int           c_off_w   = $clog2(MASK_W);
    localparam int           c_waddr_w = ADDR_W - c_off_w;
    localparam logic [IDX:0] c_ptr_one = 1;

    logic [IDX:0]                        r_rd_ptr;
    logic [IDX:0]                        r_cmt_ptr;
    logic [IDX:0]                        r_wr_ptr;
    logic [DEPTH-1:0]                    r_addr_valid;
    logic [DEPTH-1:0][ROB_ID_W-1:0]      r_rob_id;
    logic [DEPTH-1:0][c_waddr_w-1:0]     r_waddr;
    logic [DEPTH-1:0][MASK_W-1:0]        r_mask;
    logic [DEPTH-1:0][DATA_W-1:0]        r_wdata;

    logic [IDX-1:0] w_rd_idx;
    logic [IDX-1:0] w_cmt_idx;
    logic [IDX-1:0] w_wr_idx;
    logic [IDX-1:0] w_agu_idx;
    logic           w_full;
    logic           w_enq_fire;
    logic           w_cmt_fire;
    logic           w_deq_fire;
    logic           w_agu_fire;
    logic [IDX:0]   w_agu_dist;
    logic [IDX:0]   w_spec_cnt;
    logic [IDX:0]   w_cmt_ptr_nxt;
    logic           w_unused_lsbs;

    assign w_rd_idx   = r_rd_ptr[IDX-1:0];
    assign w_cmt_idx  = r_cmt_ptr[IDX-1:0];
    assign w_wr_idx   = r_wr_ptr[IDX-1:0];
    assign w_agu_idx  = agu_ptr[IDX-1:0];

    assign w_full     = (r_wr_ptr[IDX-1:0] == r_rd_ptr[IDX-1:0]) &&
                        (r_wr_ptr[IDX] != r_rd_ptr[IDX]);
    assign enq_ready  = ~w_full & ~flush;
    assign w_enq_fire = enq_valid & enq_ready;

    // Commit head must hold a resolved address before the ROB may retire it.
    assign cmt_ready  = (r_cmt_ptr != r_wr_ptr) & r_addr_valid[w_cmt_idx];
    assign cmt_rob_id = r_rob_id[w_cmt_idx];
    assign w_cmt_fire = cmt_valid & cmt_ready;
    assign w_cmt_ptr_nxt = w_cmt_fire ? (r_cmt_ptr + c_ptr_one) : r_cmt_ptr;

    // AGU results land only in the speculative region; distances from
    // cmt_ptr keep the test wrap-safe.
    assign w_agu_dist = agu_ptr - r_cmt_ptr;
    assign w_spec_cnt = r_wr_ptr - r_cmt_ptr;
    assign w_agu_fire = agu_valid & ~flush & (w_agu_dist < w_spec_cnt);

    assign dmem_valid = (r_rd_ptr != r_cmt_ptr);
    assign w_deq_fire = dmem_valid & dmem_ready;
    assign dmem_addr  = {r_waddr[w_rd_idx], {c_off_w{1'b0}}};
    assign dmem_wmask = r_mask[w_rd_idx];
    assign dmem_wdata = r_wdata[w_rd_idx];

    assign enq_ptr    = r_wr_ptr;
    assign count      = r_wr_ptr - r_rd_ptr;

    // Byte offset bits do not take part in word matching or the drain address.
    assign w_unused_lsbs = ^{agu_addr[c_off_w-1:0], ld_addr[c_off_w-1:0]};

    // Pointer and address-valid bookkeeping; flush rewinds wr_ptr to the
    // post-commit boundary so a same-cycle retirement survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_cmt_ptr    <= '0;
            r_wr_ptr     <= '0;
            r_addr_valid <= '0;
        end else begin
            r_cmt_ptr <= w_cmt_ptr_nxt;
            if (flush) begin
                r_wr_ptr <= w_cmt_ptr_nxt;
            end else if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_enq_fire) begin
                r_addr_valid[w_wr_idx] <= 1'b0;
            end
            if (w_agu_fire) begin
                r_addr_valid[w_agu_idx] <= 1'b1;
            end
            if (w_deq_fire) begin
                r_addr_valid[w_rd_idx] <= 1'b0;
            end
        end
    end

    // Entry payload; qualified by the control fields above, so no reset.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_rob_id[w_wr_idx] <= enq_rob_id;
        end
        if (w_agu_fire) begin
            r_waddr[w_agu_idx] <= agu_addr[ADDR_W-1:c_off_w];
            r_mask[w_agu_idx]  <= agu_mask;
            r_wdata[w_agu_idx] <= agu_wdata;
        end
    end

    stq_fwd_select #(
        .DEPTH   (DEPTH),
        .WADDR_W (c_waddr_w),
        .DATA_W  (DATA_W)
    ) u_fwd_select (
        .ld_valid   (ld_valid),
        .ld_waddr   (ld_addr[ADDR_W-1:c_off_w]),
        .ld_mask    (ld_mask),
        .ld_age     (ld_age),
        .rd_ptr     (r_rd_ptr),
        .addr_valid (r_addr_valid),
        .waddr      (r_waddr),
        .mask       (r_mask),
        .wdata      (r_wdata),
        .fwd_mask   (fwd_mask),
        .fwd_data   (fwd_data),
        .fwd_stall  (fwd_stall)
    );

    // Retiring a store the queue has not offered is a protocol error.
    a_cmt_legal: assert property (@(posedge clk) disable iff (!rst_n)
                                  cmt_valid |-> cmt_ready);

endmodule
`default_nettype wire

// File: tb/tb_store_queue_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_queue_commit
//  Description : Self-checking bench for store_queue_commit: directed
//                scenarios followed by randomized traffic, all compared
//                against a queue-of-stores reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_queue_commit;

    localparam int DEPTH = 8;
    localparam int IDX   = 3;
    localparam int PTRM  = 2 * DEPTH;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        enq_valid;
    logic [4:0]  enq_rob_id;
    logic        enq_ready;
    logic [IDX:0] enq_ptr;
    logic        agu_valid;
    logic [IDX:0] agu_ptr;
    logic [31:0] agu_addr;
    logic [3:0]  agu_mask;
    logic [31:0] agu_wdata;
    logic        cmt_ready;
    logic [4:0]  cmt_rob_id;
    logic        cmt_valid;
    logic        dmem_valid;
    logic        dmem_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_mask;
    logic [IDX:0] ld_age;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic [IDX:0] count;

    store_queue_commit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_rob_id (enq_rob_id),
        .enq_ready  (enq_ready),
        .enq_ptr    (enq_ptr),
        .agu_valid  (agu_valid),
        .agu_ptr    (agu_ptr),
        .agu_addr   (agu_addr),
        .agu_mask   (agu_mask),
        .agu_wdata  (agu_wdata),
        .cmt_ready  (cmt_ready),
        .cmt_rob_id (cmt_rob_id),
        .cmt_valid  (cmt_valid),
        .dmem_valid (dmem_valid),
        .dmem_ready (dmem_ready),
        .dmem_addr  (dmem_addr),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_mask    (ld_mask),
        .ld_age     (ld_age),
        .fwd_mask   (fwd_mask),
        .fwd_data   (fwd_data),
        .fwd_stall  (fwd_stall),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stores in program order, oldest first.
    typedef struct {
        logic [4:0]  rob_id;
        bit          av;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   ncm;       // number of committed stores at the head of q
    int   rd_cnt;    // total stores drained since reset
    int   agu_j;     // queue position targeted by the AGU this cycle
    int   ld_n;      // number of stores older than the load this cycle

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_cmt_ready();
        if (ncm < q.size()) return q[ncm].av;
        return 1'b0;
    endfunction

    task automatic idle();
        flush = 0; enq_valid = 0; enq_rob_id = '0;
        agu_valid = 0; agu_ptr = '0; agu_addr = '0; agu_mask = '0; agu_wdata = '0; agu_j = -1;
        cmt_valid = 0; dmem_ready = 0;
        ld_valid = 0; ld_addr = '0; ld_mask = '0; ld_age = '0; ld_n = 0;
    endtask

    task automatic set_agu(input int j, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        agu_valid = 1; agu_j = j;
        agu_ptr = (IDX+1)'((rd_cnt + j) % PTRM);
        agu_addr = a; agu_mask = m; agu_wdata = d;
    endtask

    task automatic set_ld(input int n, input logic [31:0] a, input logic [3:0] m);
        ld_valid = 1; ld_n = n;
        ld_age = (IDX+1)'((rd_cnt + n) % PTRM);
        ld_addr = a; ld_mask = m;
    endtask

    task automatic compare_outputs();
        int          sz;
        logic [3:0]  em;
        logic [31:0] ed;
        bit          es;
        sz = q.size();
        check_eq("enq_ready", enq_ready, (sz < DEPTH) && !flush);
        check_eq("enq_ptr", enq_ptr, (rd_cnt + sz) % PTRM);
        check_eq("count", count, sz);
        check_eq("cmt_ready", cmt_ready, m_cmt_ready());
        if (m_cmt_ready()) check_eq("cmt_rob_id", cmt_rob_id, q[ncm].rob_id);
        check_eq("dmem_valid", dmem_valid, ncm > 0);
        if (ncm > 0) begin
            check_eq("dmem_addr", dmem_addr, q[0].addr);
            check_eq("dmem_wmask", dmem_wmask, q[0].mask);
            check_eq("dmem_wdata", dmem_wdata, q[0].data);
        end
        em = '0; ed = '0; es = 0;
        if (ld_valid) begin
            for (int i = 0; i < ld_n; i++) begin
                if (!q[i].av) es = 1;
                else if (q[i].addr == {ld_addr[31:2], 2'b00}) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ld_mask[b] && q[i].mask[b]) begin
                            em[b] = 1'b1;
                            ed[8*b +: 8] = q[i].data[8*b +: 8];
                        end
                    end
                end
            end
        end
        check_eq("fwd_mask", fwd_mask, em);
        check_eq("fwd_data", fwd_data, ed);
        check_eq("fwd_stall", fwd_stall, es);
    endtask

    // Called at posedge+1 with inputs driven; checks, clocks, updates model.
    task automatic step();
        bit   d_fire, e_fire, c_fire, a_fire, f;
        ent_t ne;
        logic [31:0] a_addr, a_data;
        logic [3:0]  a_mask;
        int          aj;
        #1;
        compare_outputs();
        d_fire = (ncm > 0) && dmem_ready;
        e_fire = enq_valid && (q.size() < DEPTH) && !flush;
        c_fire = cmt_valid;
        a_fire = agu_valid && !flush && (agu_j >= ncm) && (agu_j < q.size());
        f = flush; aj = agu_j;
        a_addr = agu_addr; a_mask = agu_mask; a_data = agu_wdata;
        ne.rob_id = enq_rob_id; ne.av = 0; ne.addr = '0; ne.mask = '0; ne.data = '0;
        @(posedge clk);
        if (a_fire) begin
            q[aj].av = 1; q[aj].addr = {a_addr[31:2], 2'b00};
            q[aj].mask = a_mask; q[aj].data = a_data;
        end
        if (e_fire) q.push_back(ne);
        if (c_fire) ncm++;
        if (f) while (q.size() > ncm) void'(q.pop_back());
        if (d_fire) begin void'(q.pop_front()); ncm--; rd_cnt++; end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        #1;
        q.delete(); ncm = 0; rd_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic drain_all();
        for (int it = 0; it < 200 && q.size() > 0; it++) begin
            idle(); dmem_ready = 1;
            if (ncm < q.size()) begin
                if (!q[ncm].av) set_agu(ncm, 32'h400 + 32'(4 * (it % 3)), 4'hF, $urandom);
                else cmt_valid = 1;
            end
            step();
        end
        check_eq("drain_all_empty", count, 0);
    endtask

    logic [31:0] s_addr, s_data;
    logic [3:0]  s_mask;

    initial begin
        n_checks = 0; n_errors = 0;
        idle();
        rst_n = 0; q.delete(); ncm = 0; rd_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();          // reset state
        rst_n = 1;

        // Reset while committed stores are draining
        for (int i = 0; i < 3; i++) begin idle(); enq_valid = 1; enq_rob_id = 5'(i); step(); end
        for (int i = 0; i < 3; i++) begin idle(); set_agu(i, 32'h200 + 32'(4*i), 4'hF, $urandom); step(); end
        for (int i = 0; i < 3; i++) begin idle(); cmt_valid = 1; step(); end
        idle();
        check_eq("pre_rst_dmem_valid", dmem_valid, 1);
        rst_n = 0;
        #1;
        check_eq("rst_dmem_valid", dmem_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_enq_ready", enq_ready, 1);
        check_eq("rst_cmt_ready", cmt_ready, 0);
        check_eq("rst_fwd_stall", fwd_stall, 0);
        q.delete(); ncm = 0; rd_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Fill and wrap
        for (int i = 0; i < DEPTH; i++) begin idle(); enq_valid = 1; enq_rob_id = 5'(8 + i); step(); end
        idle();
        check_eq("full_enq_ready", enq_ready, 0);
        enq_valid = 1; step();      // refused while full
        idle(); set_agu(0, 32'h500, 4'h5, 32'h11223344); step();
        idle(); cmt_valid = 1; step();
        idle(); dmem_ready = 1; step();
        idle();
        check_eq("wrap_enq_ptr", enq_ptr, 8);
        enq_valid = 1; enq_rob_id = 5'd30; step();
        drain_all();

        // Flush keeps committed stores only
        do_reset();
        for (int i = 0; i < 4; i++) begin idle(); enq_valid = 1; enq_rob_id = 5'(i); step(); end
        for (int i = 0; i < 4; i++) begin idle(); set_agu(i, 32'h300 + 32'(4*i), 4'hF, 32'hA0 + 32'(i)); step(); end
        for (int i = 0; i < 2; i++) begin idle(); cmt_valid = 1; step(); end
        idle(); flush = 1; enq_valid = 1; #1;
        check_eq("flush_enq_ready", enq_ready, 0);
        step();
        idle();
        check_eq("flush_count", count, 2);
        check_eq("flush_enq_ptr", enq_ptr, 2);
        for (int i = 0; i < 2; i++) begin
            idle(); dmem_ready = 1; #1;
            check_eq("flush_drain_addr", dmem_addr, 32'h300 + 32'(4*i));
            step();
        end
        idle();
        check_eq("flush_drained", dmem_valid, 0);

        // Forwarding, age and stall
        do_reset();
        idle(); enq_valid = 1; enq_rob_id = 5'd1; step();
        idle(); enq_valid = 1; enq_rob_id = 5'd2; step();
        idle(); set_agu(0, 32'h100, 4'b0011, 32'h0000BEEF); step();
        idle(); set_agu(1, 32'h100, 4'b0010, 32'h0000AA00); step();
        idle(); set_ld(2, 32'h100, 4'hF); #1;
        check_eq("fwd_ab_mask", fwd_mask, 4'b0011);
        check_eq("fwd_ab_data", fwd_data, 32'h0000AAEF);
        check_eq("fwd_ab_stall", fwd_stall, 0);
        step();
        idle(); set_ld(1, 32'h100, 4'hF); #1;
        check_eq("fwd_young_data", fwd_data, 32'h0000BEEF);
        step();
        idle(); enq_valid = 1; enq_rob_id = 5'd3; step();
        idle(); set_ld(3, 32'h100, 4'hF); #1;
        check_eq("fwd_stall_old", fwd_stall, 1);
        step();
        idle(); set_ld(2, 32'h100, 4'hF); #1;
        check_eq("fwd_nostall_young", fwd_stall, 0);
        step();

        // Backpressure: drain head stays stable while traffic continues
        idle(); cmt_valid = 1; step();
        idle(); cmt_valid = 1; step();
        idle();
        s_addr = dmem_addr; s_mask = dmem_wmask; s_data = dmem_wdata;
        for (int i = 0; i < 5; i++) begin
            idle();
            enq_valid = 1; enq_rob_id = 5'(10 + i);
            if (m_cmt_ready()) cmt_valid = 1;
            else if (ncm < q.size()) set_agu(ncm, 32'h600, 4'hC, $urandom);
            step();
            check_eq("bp_addr", dmem_addr, s_addr);
            check_eq("bp_mask", dmem_wmask, s_mask);
            check_eq("bp_data", dmem_wdata, s_data);
        end
        drain_all();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            idle();
            enq_valid = ($urandom % 2) == 0;
            enq_rob_id = 5'($urandom);
            if (q.size() > 0 && ($urandom % 3) != 0)
                set_agu(int'($urandom % q.size()), 32'h100 + 32'(4 * ($urandom % 3)) + 32'($urandom % 4),
                        4'($urandom_range(1, 15)), $urandom);
            cmt_valid = m_cmt_ready() && (($urandom % 2) == 0);
            dmem_ready = ($urandom % 3) != 0;
            flush = ($urandom % 20) == 0;
            if (($urandom % 2) == 0)
                set_ld(int'($urandom % (q.size() + 1)), 32'h100 + 32'(4 * ($urandom % 3)) + 32'($urandom % 4),
                       4'($urandom));
            step();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
